// File: rtl/line_raster_ctrl.sv
// line_raster_ctrl: accepts one line command at a time and streams its
// pixels over a valid/ready interface, one pixel per cycle at full rate.
// The Bresenham-style stepping is done origin-relative by point_gen, which
// is defined after the controller in this file.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; x0,y0,x1,y1 signed 10-bit endpoints
//   pix_valid/pix_ready      pixel handshake; pix_x,pix_y signed 10-bit, pix_last
//   busy                     controller not idle
//   done                     one-cycle pulse after the last pixel is consumed
//   err                      one-cycle pulse for a rejected command
//
// Config macro: LINE_RASTER_STEEP_EN -- when defined, steep lines are drawn by
// swapping axes; when undefined, steep commands are rejected with err.
module line_raster_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] x0,
  input  logic [9:0] y0,
  input  logic [9:0] x1,
  input  logic [9:0] y1,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW       = 10;
  localparam int unsigned DW       = 11;
  localparam int unsigned MAX_SPAN = 511;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic signed [CW-1:0] cx0, cy0, cx1, cy1;
  logic signed [CW-1:0] cx0_nxt, cy0_nxt, cx1_nxt, cy1_nxt;
  logic signed [CW-1:0] ox, oy, ox_nxt, oy_nxt;
  logic signed [DW-1:0] dx, dy, rx, ry;
  logic signed [DW-1:0] dx_nxt, dy_nxt, rx_nxt, ry_nxt;
  logic                 dir, dir_nxt;
`ifdef LINE_RASTER_STEEP_EN
  logic                 steep, steep_nxt;
`endif

  logic                 cmd_ready_nxt, pix_valid_nxt, pix_last_nxt;
  logic                 busy_nxt, done_nxt, err_nxt;
  logic [CW-1:0]        pix_x_nxt, pix_y_nxt;

  logic [DW-1:0]        span_x, span_y;
  logic                 reject;
  logic signed [CW-1:0] wx0, wy0, wx1, wy1;
  logic signed [CW-1:0] ox_w, oy_w, xe_w, ye_w;
  logic                 swap_ends;
  logic signed [DW-1:0] step_x, step_y;
  logic                 load_pix;

  function automatic logic [DW-1:0] abs_span(input logic signed [CW-1:0] a,
                                             input logic signed [CW-1:0] b);
    logic signed [DW-1:0] d;
    d = DW'(b) - DW'(a);
    return d[DW-1] ? DW'(-d) : DW'(d);
  endfunction

  // Command screening on the raw ports; the verdict is registered as err so
  // it shows during SETUP.
  always_comb begin
    span_x = abs_span($signed(x0), $signed(x1));
    span_y = abs_span($signed(y0), $signed(y1));
`ifdef LINE_RASTER_STEEP_EN
    reject = (span_x > DW'(MAX_SPAN)) || (span_y > DW'(MAX_SPAN));
`else
    reject = (span_x > DW'(MAX_SPAN)) || (span_y > DW'(MAX_SPAN)) || (span_y > span_x);
`endif
  end

  // Working-axis endpoints, ordered so the working dx is never negative.
  always_comb begin
`ifdef LINE_RASTER_STEEP_EN
    if (steep) begin
      wx0 = cy0; wy0 = cx0; wx1 = cy1; wy1 = cx1;
    end else begin
      wx0 = cx0; wy0 = cy0; wx1 = cx1; wy1 = cy1;
    end
`else
    wx0 = cx0; wy0 = cy0; wx1 = cx1; wy1 = cy1;
`endif
    swap_ends = wx0 > wx1;
    ox_w = swap_ends ? wx1 : wx0;
    oy_w = swap_ends ? wy1 : wy0;
    xe_w = swap_ends ? wx0 : wx1;
    ye_w = swap_ends ? wy0 : wy1;
  end

  point_gen u_point_gen (
    .x_i    (rx),
    .y_i    (ry),
    .dy     (dy),
    .dx     (dx),
    .p_or_n (dir),
    .xn     (step_x),
    .yn     (step_y)
  );

  // Next-state and next-register/output values.
  always_comb begin
    state_nxt     = state;
    cx0_nxt       = cx0;
    cy0_nxt       = cy0;
    cx1_nxt       = cx1;
    cy1_nxt       = cy1;
    ox_nxt        = ox;
    oy_nxt        = oy;
    dx_nxt        = dx;
    dy_nxt        = dy;
    rx_nxt        = rx;
    ry_nxt        = ry;
    dir_nxt       = dir;
`ifdef LINE_RASTER_STEEP_EN
    steep_nxt     = steep;
`endif
    pix_valid_nxt = pix_valid;
    pix_last_nxt  = pix_last;
    pix_x_nxt     = pix_x;
    pix_y_nxt     = pix_y;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    load_pix      = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt = SETUP;
          cx0_nxt   = $signed(x0);
          cy0_nxt   = $signed(y0);
          cx1_nxt   = $signed(x1);
          cy1_nxt   = $signed(y1);
          err_nxt   = reject;
`ifdef LINE_RASTER_STEEP_EN
          steep_nxt = span_y > span_x;
`endif
        end
      end
      SETUP: begin
        if (err) begin
          state_nxt = IDLE;
        end else begin
          state_nxt     = DRAW;
          ox_nxt        = ox_w;
          oy_nxt        = oy_w;
          dx_nxt        = DW'(xe_w) - DW'(ox_w);
          dy_nxt        = DW'(ye_w) - DW'(oy_w);
          dir_nxt       = ye_w < oy_w;
          rx_nxt        = '0;
          ry_nxt        = '0;
          pix_valid_nxt = 1'b1;
          load_pix      = 1'b1;
        end
      end
      DRAW: begin
        if (pix_valid && pix_ready) begin
          if (pix_last) begin
            state_nxt     = DONE;
            pix_valid_nxt = 1'b0;
            pix_last_nxt  = 1'b0;
            done_nxt      = 1'b1;
          end else begin
            rx_nxt   = step_x;
            ry_nxt   = step_y;
            load_pix = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Present the (next) cursor position in screen axes.
    if (load_pix) begin
      pix_last_nxt = rx_nxt == dx_nxt;
`ifdef LINE_RASTER_STEEP_EN
      if (steep_nxt) begin
        pix_x_nxt = CW'(oy_nxt + ry_nxt);
        pix_y_nxt = CW'(ox_nxt + rx_nxt);
      end else begin
        pix_x_nxt = CW'(ox_nxt + rx_nxt);
        pix_y_nxt = CW'(oy_nxt + ry_nxt);
      end
`else
      pix_x_nxt = CW'(ox_nxt + rx_nxt);
      pix_y_nxt = CW'(oy_nxt + ry_nxt);
`endif
    end

    cmd_ready_nxt = state_nxt == IDLE;
    busy_nxt      = state_nxt != IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cx0       <= '0;
      cy0       <= '0;
      cx1       <= '0;
      cy1       <= '0;
      ox        <= '0;
      oy        <= '0;
      dx        <= '0;
      dy        <= '0;
      rx        <= '0;
      ry        <= '0;
      dir       <= 1'b0;
`ifdef LINE_RASTER_STEEP_EN
      steep     <= 1'b0;
`endif
      cmd_ready <= 1'b0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cx0       <= cx0_nxt;
      cy0       <= cy0_nxt;
      cx1       <= cx1_nxt;
      cy1       <= cy1_nxt;
      ox        <= ox_nxt;
      oy        <= oy_nxt;
      dx        <= dx_nxt;
      dy        <= dy_nxt;
      rx        <= rx_nxt;
      ry        <= ry_nxt;
      dir       <= dir_nxt;
`ifdef LINE_RASTER_STEEP_EN
      steep     <= steep_nxt;
`endif
      cmd_ready <= cmd_ready_nxt;
      pix_valid <= pix_valid_nxt;
      pix_last  <= pix_last_nxt;
      pix_x     <= pix_x_nxt;
      pix_y     <= pix_y_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// point_gen: one origin-relative line step. Advances x by one and moves y by
// one toward the line (sign chosen by p_or_n) when 2*(dy*xn - dx*y_i) passes
// dx; an exact half-pixel tie keeps y.
module point_gen (
  input  logic signed [10:0] x_i,
  input  logic signed [10:0] y_i,
  input  logic signed [10:0] dy,
  input  logic signed [10:0] dx,
  input  logic               p_or_n,
  output logic signed [10:0] xn,
  output logic signed [10:0] yn
);

  localparam int unsigned PW = 24;

  logic signed [PW-1:0] err2, dxe;
  logic                 step_up, step_dn;

  always_comb begin
    xn      = x_i + 11'sd1;
    err2    = (PW'(dy) * PW'(xn) - PW'(dx) * PW'(y_i)) <<< 1;
    dxe     = PW'(dx);
    step_up = !p_or_n && (err2 > dxe);
    step_dn = p_or_n && ((-err2) > dxe);
    yn      = y_i;
    if (step_up)      yn = y_i + 11'sd1;
    else if (step_dn) yn = y_i - 11'sd1;
  end

endmodule

// File: tb/tb_line_raster_ctrl.sv
// tb_line_raster_ctrl: directed commands with hand-computed pixel lists,
// pushed into a scoreboard queue and checked by an independent monitor.
module tb_line_raster_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] x0, y0, x1, y1;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x, pix_y;
  logic       pix_last;
  logic       busy;
  logic       done;
  logic       err;

  line_raster_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  pix_t pix_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc = 0;
  int   err_exp = 0;
  bit   mon_en = 1'b0;
  bit   done_due = 1'b0;
  bit   toggle_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int x, input int y, input bit last);
    pix_t p;
    p.x = x;
    p.y = y;
    p.last = last;
    pix_q.push_back(p);
  endtask

  task automatic send_cmd(input int ax0, input int ay0, input int ax1, input int ay1);
    int n = 0;
    @(posedge clk);
    #1;
    x0 = 10'(ax0);
    y0 = 10'(ay0);
    x1 = 10'(ax1);
    y1 = 10'(ay1);
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_ready !== 1'b1 && n < 2000);
    if (cmd_ready !== 1'b1) check("cmd_accept_timeout", cmd_ready, 1);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int gap);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_ready !== 1'b1 && n < 2000);
    if (cmd_ready !== 1'b1) check("idle_timeout", cmd_ready, 1);
    else if (gap >= 0) check("cmd_spacing", cyc - acc, gap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_last"}, pix_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
  endtask

  // Monitor: compares every presented pixel against the queue head (so stall
  // cycles must hold the same pixel), pops on handshake, and tracks done/err.
  always @(negedge clk) begin
    pix_t e;
    if (mon_en) begin
      if (done || done_due) check("done_pulse", done, done_due);
      done_due = 1'b0;
      if (err) begin
        check("err_pulse_expected", int'(err_exp > 0), 1);
        if (err_exp > 0) err_exp--;
      end
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          check("pix_unexpected", pix_valid, 0);
        end else begin
          e = pix_q[0];
          check("pix_x", $signed(pix_x), e.x);
          check("pix_y", $signed(pix_y), e.y);
          check("pix_last", pix_last, e.last);
          if (pix_ready) begin
            void'(pix_q.pop_front());
            if (e.last) done_due = 1'b1;
          end
        end
      end
    end
  end

  // Downstream ready: constant high, or toggling every cycle.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = toggle_mode ? ~pix_ready : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);
    mon_en = 1'b1;

    // Shallow line, with a command waved at the busy controller.
    push(0, 0, 0); push(1, 0, 0); push(2, 1, 0); push(3, 1, 0); push(4, 2, 1);
    send_cmd(0, 0, 4, 2);
    @(negedge clk);
    check("setup_busy", busy, 1);
    check("setup_pix_valid", pix_valid, 0);
    check("setup_cmd_ready", cmd_ready, 0);
    x1 = 10'(20);
    cmd_valid = 1'b1;
    @(negedge clk);
    check("first_pix_latency", pix_valid, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle(7);

    // Reversed endpoints.
    push(1, 3, 0); push(2, 3, 0); push(3, 4, 0); push(4, 4, 0); push(5, 5, 1);
    send_cmd(5, 5, 1, 3);
    wait_idle(7);

    // Steep line.
`ifdef LINE_RASTER_STEEP_EN
    push(2, 0, 0); push(2, 1, 0); push(2, 2, 0); push(2, 3, 0);
    push(3, 4, 0); push(3, 5, 0); push(3, 6, 1);
    send_cmd(2, 0, 3, 6);
    wait_idle(9);
`else
    err_exp++;
    send_cmd(2, 0, 3, 6);
    wait_idle(1);
`endif

    // Descending line with a stalling consumer.
    toggle_mode = 1'b1;
    push(0, 0, 0); push(1, -1, 0); push(2, -2, 0); push(3, -3, 1);
    send_cmd(0, 0, 3, -3);
    wait_idle(-1);
    toggle_mode = 1'b0;

    // Span too wide.
    err_exp++;
    send_cmd(-300, 0, 300, 0);
    wait_idle(1);

    // Degenerate single-point line.
    push(7, 7, 1);
    send_cmd(7, 7, 7, 7);
    wait_idle(3);

    // Reset on the third pixel of a long line.
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0);
    send_cmd(0, 0, 10, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("midline_reset");
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_midline_reset", cmd_ready, 1);

    push(0, 0, 0); push(1, 0, 0); push(2, -1, 1);
    send_cmd(0, 0, 2, -1);
    wait_idle(5);

    repeat (3) @(negedge clk);
    check("pixels_outstanding", pix_q.size(), 0);
    check("errs_outstanding", err_exp, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
